pc_sequencer: RTL and testbench

Fetch-stage PC controller for the 5-stage pipeline. Owns the PC register and sequences it: sequential +4 fetch, hold on hazard stall or instruction-memory wait, and redirect to branch targets formed as branch PC plus word offset shifted left by 2. Generates the IF/ID flush pulses on redirect. Keeps the instruction-memory request stable while a redirect is held pending. Sits between the EX-stage branch resolution, the hazard unit and instruction memory.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bundle between the PC sequencer, EX-stage branch resolution,
// the hazard unit and instruction memory.
interface pc_sequencer_if;
    logic        stall_i;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [31:0] br_pc_i;
    logic [31:0] br_offset_i;
    logic        imem_ready_i;
    logic        imem_req_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        if_flush_o;
    logic        id_flush_o;
    logic [1:0]  state_o;

    // The sequencer masters the fetch address towards instruction memory.
    modport master (
        input  stall_i, br_valid_i, br_taken_i, br_pc_i, br_offset_i, imem_ready_i,
        output imem_req_o, pc_o, pc_plus4_o, fetch_valid_o, if_flush_o, id_flush_o, state_o
    );

    modport slave (
        output stall_i, br_valid_i, br_taken_i, br_pc_i, br_offset_i, imem_ready_i,
        input  imem_req_o, pc_o, pc_plus4_o, fetch_valid_o, if_flush_o, id_flush_o, state_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: sequential +4 fetch, stall/imem-wait hold,
// branch redirect (immediate or pending behind an in-flight fetch) and IF/ID flush.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect = bus.br_valid_i & bus.br_taken_i;
    // Top two offset bits fall off the shift; the add wraps mod 2^32.
    assign target   = bus.br_pc_i + {bus.br_offset_i[29:0], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is asynchronous so outputs settle on assertion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0000_0000;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;

            ST_RUN, ST_WAIT: begin
                if (redirect) begin
                    flush_d = 1'b1;
                    if (bus.imem_ready_i) begin
                        pc_d    = target;
                        state_d = ST_RUN;
                    end else begin
                        // Fetch at pc_q still in flight: park the target.
                        pend_d  = target;
                        state_d = ST_PEND;
                    end
                end else if (!bus.imem_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (!bus.stall_i) pc_d = pc_plus4;
                end
            end

            ST_PEND: begin
                if (redirect) begin
                    flush_d = 1'b1;
                    if (bus.imem_ready_i) begin
                        pc_d    = target;
                        state_d = ST_RUN;
                    end else begin
                        pend_d  = target;
                    end
                end else if (bus.imem_ready_i) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end

            default: state_d = ST_BOOT;
        endcase
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_plus4;
    assign bus.imem_req_o    = (state_q != ST_BOOT);
    assign bus.fetch_valid_o = bus.imem_ready_i & ~redirect &
                               ((state_q == ST_RUN) | (state_q == ST_WAIT));
    assign bus.if_flush_o    = flush_q;
    assign bus.id_flush_o    = flush_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes the expected per-cycle
// outputs into a queue, a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  state;
        logic        req;
        logic        fv;
        logic        flush;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".pc"},       bus.pc_o,                  e.pc);
            check({e.name, ".pc_plus4"}, bus.pc_plus4_o,            e.pc + 32'd4);
            check({e.name, ".state"},    {30'd0, bus.state_o},      {30'd0, e.state});
            check({e.name, ".req"},      {31'd0, bus.imem_req_o},   {31'd0, e.req});
            check({e.name, ".fv"},       {31'd0, bus.fetch_valid_o}, {31'd0, e.fv});
            check({e.name, ".if_flush"}, {31'd0, bus.if_flush_o},   {31'd0, e.flush});
            check({e.name, ".id_flush"}, {31'd0, bus.id_flush_o},   {31'd0, e.flush});
        end
    end

    task automatic drive(input logic st, input logic bv, input logic bt,
                         input logic [31:0] bpc, input logic [31:0] boff, input logic rdy);
        bus.stall_i      = st;
        bus.br_valid_i   = bv;
        bus.br_taken_i   = bt;
        bus.br_pc_i      = bpc;
        bus.br_offset_i  = boff;
        bus.imem_ready_i = rdy;
    endtask

    task automatic push(input string name, input logic [31:0] pc, input logic [1:0] state,
                        input logic fv, input logic flush);
        exp_t e;
        e.name  = name;
        e.pc    = pc;
        e.state = state;
        e.req   = (state != 2'd0);
        e.fv    = fv;
        e.flush = flush;
        exp_q.push_back(e);
    endtask

    // One cycle: inputs for the coming edge, expected outputs of the current cycle.
    task automatic cyc(input string name, input logic st, input logic bv, input logic bt,
                       input logic [31:0] bpc, input logic [31:0] boff, input logic rdy,
                       input logic [31:0] pc, input logic [1:0] state,
                       input logic fv, input logic flush);
        @(posedge clk);
        #1;
        drive(st, bv, bt, bpc, boff, rdy);
        push(name, pc, state, fv, flush);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        #1 push("reset", RST_PC, 2'd0, 0, 0);
        #6 reset = 1'b0;

        //   name      st bv bt br_pc          br_off         rdy  pc            state fv fl
        cyc("boot_run", 0, 0, 0, 32'h0,         32'h0,         1,  32'h100,      1,    1, 0);
        cyc("seq1",     0, 0, 0, 32'h0,         32'h0,         1,  32'h104,      1,    1, 0);
        cyc("to200",    0, 1, 1, 32'h0,         32'h80,        1,  32'h108,      1,    0, 0);
        cyc("stall1",   1, 0, 0, 32'h0,         32'h0,         1,  32'h200,      1,    1, 1);
        cyc("stall2",   1, 0, 0, 32'h0,         32'h0,         1,  32'h200,      1,    1, 0);
        cyc("unstall",  0, 0, 0, 32'h0,         32'h0,         1,  32'h200,      1,    1, 0);
        cyc("br_neg",   0, 1, 1, 32'h400,       32'hFFFF_FFFE, 1,  32'h204,      1,    0, 0);
        cyc("br_tgt",   0, 0, 0, 32'h0,         32'h0,         1,  32'h3F8,      1,    1, 1);
        cyc("br_seq",   0, 0, 0, 32'h0,         32'h0,         1,  32'h3FC,      1,    1, 0);
        cyc("br_stall", 1, 1, 1, 32'h400,       32'hFFFF_FFFE, 1,  32'h400,      1,    0, 0);
        cyc("brst_tgt", 0, 0, 0, 32'h0,         32'h0,         1,  32'h3F8,      1,    1, 1);
        cyc("to300",    0, 1, 1, 32'h300,       32'h0,         1,  32'h3FC,      1,    0, 0);
        cyc("pend_in",  0, 1, 1, 32'h500,       32'h0,         0,  32'h300,      1,    0, 1);
        cyc("pend1",    0, 0, 0, 32'h0,         32'h0,         0,  32'h300,      3,    0, 1);
        cyc("pend2",    1, 0, 0, 32'h0,         32'h0,         0,  32'h300,      3,    0, 0);
        cyc("pend3",    0, 0, 0, 32'h0,         32'h0,         0,  32'h300,      3,    0, 0);
        cyc("pend_rdy", 0, 0, 0, 32'h0,         32'h0,         1,  32'h300,      3,    0, 0);
        cyc("pend_out", 0, 0, 0, 32'h0,         32'h0,         1,  32'h500,      1,    1, 0);
        cyc("wait_in",  0, 0, 0, 32'h0,         32'h0,         0,  32'h504,      1,    0, 0);
        cyc("wait_st",  1, 0, 0, 32'h0,         32'h0,         0,  32'h504,      2,    0, 0);
        cyc("wait_rdy", 0, 0, 0, 32'h0,         32'h0,         1,  32'h504,      2,    1, 0);
        cyc("p2_first", 0, 1, 1, 32'h500,       32'h0,         0,  32'h508,      1,    0, 0);
        cyc("p2_secnd", 0, 1, 1, 32'h600,       32'h0,         0,  32'h508,      3,    0, 1);
        cyc("p2_flush", 0, 0, 0, 32'h0,         32'h0,         0,  32'h508,      3,    0, 1);
        cyc("p2_rdy",   0, 0, 0, 32'h0,         32'h0,         1,  32'h508,      3,    0, 0);
        cyc("p2_out",   0, 0, 0, 32'h0,         32'h0,         1,  32'h600,      1,    1, 0);
        cyc("nottaken", 0, 1, 0, 32'h900,       32'h0,         1,  32'h604,      1,    1, 0);
        cyc("to_top",   0, 1, 1, 32'hFFFF_FFFC, 32'h0,         1,  32'h608,      1,    0, 0);
        cyc("top",      0, 0, 0, 32'h0,         32'h0,         1,  32'hFFFF_FFFC, 1,   1, 1);
        cyc("wrap",     0, 1, 1, 32'h10,        32'hC000_0001, 1,  32'h0,        1,    0, 0);
        cyc("off_trim", 0, 1, 1, 32'h700,       32'h0,         0,  32'h14,       1,    0, 1);
        cyc("pend_rst", 0, 0, 0, 32'h0,         32'h0,         0,  32'h14,       3,    0, 1);

        // Asynchronous reset mid-cycle while PEND holds target 0x700.
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(0, 1, 1, 32'h900, 32'h0, 1);
        push("async_rst", RST_PC, 2'd0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        push("boot_hold", RST_PC, 2'd0, 0, 0);

        cyc("post_rst", 0, 0, 0, 32'h0,         32'h0,         1,  RST_PC,       1,    1, 0);
        cyc("post_seq", 0, 0, 0, 32'h0,         32'h0,         1,  RST_PC + 32'd4, 1,  1, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
